// File: rtl/div_pkg.sv
// Shared definitions for the programmable clock-enable divider:
// FSM state encoding and the default phase lengths used after reset.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } div_state_e;

  localparam int DEF_HIGH_LEN = 6;
  localparam int DEF_LOW_LEN  = 6;

endpackage

// File: rtl/div_phase_counter.sv
// Down-counter shared by the high and low phases. It is loaded with
// (phase length - 1) on the first cycle of a phase; tc marks the last cycle.
module div_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Load has priority; counting stops at zero so an idle counter stays put
  always_ff @(posedge clk) begin
    if (rst)                       cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (cnt_en && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/param_clock_divider.sv
// Runtime-programmable divided clock with independent high/low phase
// lengths, registered rise/fall strobes and shadowed configuration that
// is applied only at period boundaries (or while idle).
// Optional mid-low-phase strobe: define PARAM_CLOCK_DIVIDER_MID_STROBE_EN.
module param_clock_divider
  import div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = DEF_HIGH_LEN,
  parameter int DEF_LOW  = DEF_LOW_LEN
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             div_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy,
  output logic             mid_low_stb
);

  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LOW);

  // A zero length behaves as one cycle; the counter is loaded with len-1
  function automatic logic [CNT_W-1:0] ld_val(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] act_high, act_low, shd_high, shd_low, eff_high;
  logic             apply, load, cnt_en, tc;
  logic [CNT_W-1:0] load_val, cnt;

  // A pending shadow takes effect on the HIGH entry that applies it
  assign eff_high = busy ? shd_high : act_high;

  div_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clock50),
    .rst      (reset),
    .load     (load),
    .load_val (load_val),
    .cnt_en   (cnt_en),
    .cnt      (cnt),
    .tc       (tc)
  );

  // Next-state, counter control and shadow-apply decision
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    cnt_en   = 1'b0;
    apply    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        apply = busy;
        if (enable) begin
          state_d  = ST_HIGH;
          load     = 1'b1;
          load_val = ld_val(eff_high);
        end
      end
      ST_HIGH: begin
        if (tc) begin
          state_d  = ST_LOW;
          load     = 1'b1;
          load_val = ld_val(act_low);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (tc) begin
          if (enable) begin
            state_d  = ST_HIGH;
            load     = 1'b1;
            load_val = ld_val(eff_high);
            apply    = busy;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and registered clock/strobe outputs
  always_ff @(posedge clock50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_clk  <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_clk  <= (state_d == ST_HIGH);
      rise_stb <= (state_d == ST_HIGH) && (state_q != ST_HIGH);
      fall_stb <= (state_d == ST_LOW)  && (state_q != ST_LOW);
    end
  end

  // Shadow capture and apply; a load on the apply cycle keeps busy set
  always_ff @(posedge clock50) begin
    if (reset) begin
      act_high <= DEF_H;
      act_low  <= DEF_L;
      shd_high <= DEF_H;
      shd_low  <= DEF_L;
      busy     <= 1'b0;
    end else begin
      if (apply) begin
        act_high <= shd_high;
        act_low  <= shd_low;
      end
      if (cfg_load) begin
        shd_high <= cfg_high;
        shd_low  <= cfg_low;
        busy     <= 1'b1;
      end else if (apply) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef PARAM_CLOCK_DIVIDER_MID_STROBE_EN
  logic [CNT_W-1:0] cnt_nxt, low_c, mid_cnt;

  // LOW index floor(low/2) corresponds to a remaining count of
  // (low-1) - floor(low/2); predict it from the counter's next value
  always_comb begin
    low_c   = (act_low == '0) ? CNT_W'(1) : act_low;
    mid_cnt = ld_val(act_low) - (low_c >> 1);
    if (load)                     cnt_nxt = load_val;
    else if (cnt_en && cnt != '0) cnt_nxt = cnt - CNT_W'(1);
    else                          cnt_nxt = cnt;
  end

  // Registered mid-low strobe, aligned with the other strobes
  always_ff @(posedge clock50) begin
    if (reset) mid_low_stb <= 1'b0;
    else       mid_low_stb <= (state_d == ST_LOW) && (cnt_nxt == mid_cnt);
  end
`else
  logic unused_cnt;
  assign unused_cnt  = ^cnt;
  assign mid_low_stb = 1'b0;
`endif

endmodule

// File: tb/tb_param_clock_divider.sv
// Directed bench for param_clock_divider: default periods, reconfiguration,
// clamp to 1/1, enable stop/restart, idle apply and mid-operation reset.
module tb_param_clock_divider;

  logic       clock50 = 1'b0;
  logic       reset, enable, cfg_load;
  logic [7:0] cfg_high, cfg_low;
  logic       div_clk, rise_stb, fall_stb, busy, mid_low_stb;

  int n_tests = 0;
  int n_fail  = 0;

  param_clock_divider #(.CNT_W(8), .DEF_HIGH(6), .DEF_LOW(6)) dut (
    .clock50     (clock50),
    .reset       (reset),
    .enable      (enable),
    .cfg_load    (cfg_load),
    .cfg_high    (cfg_high),
    .cfg_low     (cfg_low),
    .div_clk     (div_clk),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .busy        (busy),
    .mid_low_stb (mid_low_stb)
  );

  always #5 clock50 = ~clock50;

  task automatic tick();
    @(posedge clock50);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check cycles start..start+n-1 of an h/l period. Optionally pulse
  // cfg_load with lh/ll during cycle ld_idx; busy expected b0 until then.
  task automatic run_period(input string tag, input int h, input int l,
                            input int start, input int n, input int ld_idx,
                            input logic [7:0] lh, input logic [7:0] ll,
                            input logic b0);
    logic b;
    logic m;
    b = b0;
    for (int i = start; i < start + n; i++) begin
`ifdef PARAM_CLOCK_DIVIDER_MID_STROBE_EN
      m = (i == h + l / 2);
`else
      m = 1'b0;
`endif
      chk($sformatf("%s div_clk i=%0d", tag, i), div_clk, i < h);
      chk($sformatf("%s rise i=%0d", tag, i), rise_stb, i == 0);
      chk($sformatf("%s fall i=%0d", tag, i), fall_stb, i == h);
      chk($sformatf("%s busy i=%0d", tag, i), busy, b);
      chk($sformatf("%s mid i=%0d", tag, i), mid_low_stb, m);
      if (i == ld_idx) begin
        cfg_load = 1'b1;
        cfg_high = lh;
        cfg_low  = ll;
      end
      tick();
      cfg_load = 1'b0;
      if (i == ld_idx) b = 1'b1;
    end
  endtask

  task automatic chk_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s div_clk %0d", tag, i), div_clk, 1'b0);
      chk($sformatf("%s rise %0d", tag, i), rise_stb, 1'b0);
      chk($sformatf("%s fall %0d", tag, i), fall_stb, 1'b0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0;
    cfg_high = 8'd0; cfg_low = 8'd0;
    tick(); tick();
    chk("rst div_clk", div_clk, 1'b0);
    chk("rst rise", rise_stb, 1'b0);
    chk("rst fall", fall_stb, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst mid", mid_low_stb, 1'b0);

    // Defaults with enable from cycle 0: HIGH cycles 1-6, LOW 7-12
    reset = 1'b0; enable = 1'b1;
    tick();
    run_period("def0", 6, 6, 0, 12, -1, 8'd0, 8'd0, 1'b0);
    // Rise again at cycle 13; load 3/2 in HIGH cycle 2
    run_period("def1", 6, 6, 0, 12, 2, 8'd3, 8'd2, 1'b0);
    run_period("p32", 3, 2, 0, 5, 0, 8'd0, 8'd0, 1'b0);
    // 0/0 clamps to 1/1
    run_period("p11a", 1, 1, 0, 2, -1, 8'd0, 8'd0, 1'b0);
    run_period("p11b", 1, 1, 0, 2, 0, 8'd3, 8'd2, 1'b0);
    // Reset in the first LOW cycle of a 3/2 period
    run_period("p32r", 3, 2, 0, 3, -1, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst div_clk", div_clk, 1'b0);
    chk("midrst rise", rise_stb, 1'b0);
    chk("midrst fall", fall_stb, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst mid", mid_low_stb, 1'b0);
    reset = 1'b0;
    tick();
    run_period("post_rst", 6, 6, 0, 12, -1, 8'd0, 8'd0, 1'b0);

    // Enable drops in HIGH cycle 2: period completes, then idle
    run_period("drop_a", 6, 6, 0, 2, -1, 8'd0, 8'd0, 1'b0);
    enable = 1'b0;
    run_period("drop_b", 6, 6, 2, 10, -1, 8'd0, 8'd0, 1'b0);
    chk_idle("stop", 4);

    // Load while idle: busy set, then cleared by the idle apply
    cfg_load = 1'b1; cfg_high = 8'd4; cfg_low = 8'd3;
    tick();
    cfg_load = 1'b0;
    chk("idle busy set", busy, 1'b1);
    tick();
    chk("idle busy clr", busy, 1'b0);
    chk("idle div_clk", div_clk, 1'b0);

    // 4/3 with enable dropped in HIGH and restored in LOW: no gap
    enable = 1'b1;
    tick();
    run_period("g_a", 4, 3, 0, 2, -1, 8'd0, 8'd0, 1'b0);
    enable = 1'b0;
    run_period("g_b", 4, 3, 2, 3, -1, 8'd0, 8'd0, 1'b0);
    enable = 1'b1;
    run_period("g_c", 4, 3, 5, 2, -1, 8'd0, 8'd0, 1'b0);
    enable = 1'b0;
    run_period("g_d", 4, 3, 0, 7, -1, 8'd0, 8'd0, 1'b0);
    chk_idle("end", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
